// File: rtl/cpu_issue_arb_if.sv
// Issue-arbiter bus: two requesters' instruction/immediate words and the
// handshake back to them, plus the run/data/done link to the CPU.
// The master side is the environment (requesters and CPU); the slave side
// is the arbiter itself.
interface cpu_issue_arb_if #(
    parameter int DATA_W = 9
);
    logic [1:0]        req;
    logic [DATA_W-1:0] instr0;
    logic [DATA_W-1:0] instr1;
    logic [DATA_W-1:0] imm0;
    logic [DATA_W-1:0] imm1;
    logic [1:0]        ack;
    logic              err;
    logic              busy;
    logic              grant_id;
    logic              cpu_run;
    logic [DATA_W-1:0] cpu_din;
    logic              cpu_done;

    modport master (
        output req, instr0, instr1, imm0, imm1, cpu_done,
        input  ack, err, busy, grant_id, cpu_run, cpu_din
    );

    modport slave (
        input  req, instr0, instr1, imm0, imm1, cpu_done,
        output ack, err, busy, grant_id, cpu_run, cpu_din
    );
endinterface

// File: rtl/cpu_issue_arb.sv
// Two-requester round-robin arbiter that issues one instruction (plus an
// optional immediate word for MVI_OP) to the CPU, waits for cpu_done with a
// timeout, and returns a one-cycle ack/err to the winning requester.
module cpu_issue_arb #(
    parameter int         DATA_W  = 9,
    parameter int         TIMEOUT = 64,
    parameter logic [2:0] MVI_OP  = 3'b001
) (
    input logic            clock,
    input logic            resetn,
    cpu_issue_arb_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, IMM, WAIT, RESP} state_t;

    // Words captured at grant; held until the transaction completes.
    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] imm;
    } txn_t;

    state_t            state, state_nxt;
    txn_t              txn;
    logic              ptr;
    logic              grant_q;
    logic              winner;
    logic              err_q;
    logic              timed_out;
    logic [CNT_W-1:0]  cnt;

    logic [1:0]        ack_c;
    logic              err_c;
    logic              busy_c;
    logic              run_c;
    logic [DATA_W-1:0] din_c;

    // Pointer breaks ties; a lone requester wins regardless of the pointer.
    always_comb begin
        winner    = (bus.req == 2'b11) ? ptr : bus.req[1];
        timed_out = (cnt == CNT_W'(TIMEOUT - 1));
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; cpu_done is only looked at in WAIT, and wins over a
    // timeout landing on the same edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|bus.req) state_nxt = ISSUE;
            ISSUE:   state_nxt = (txn.instr[8:6] == MVI_OP) ? IMM : WAIT;
            IMM:     state_nxt = WAIT;
            WAIT:    if (bus.cpu_done || timed_out) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant capture, round-robin pointer, wait counter and completion status.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            txn     <= '0;
            grant_q <= 1'b0;
            ptr     <= 1'b0;
            cnt     <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && |bus.req) begin
                txn.instr <= winner ? bus.instr1 : bus.instr0;
                txn.imm   <= winner ? bus.imm1   : bus.imm0;
                grant_q   <= winner;
                ptr       <= ~winner;
            end
            // Cleared in every other state, so it starts at 0 on WAIT entry.
            if (state != WAIT)                 cnt <= '0;
            else if (cnt != CNT_W'(TIMEOUT))   cnt <= cnt + 1'b1;
            // The last WAIT cycle decides: done -> clean, otherwise timeout.
            if (state == WAIT) err_q <= ~bus.cpu_done;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        ack_c  = 2'b00;
        err_c  = 1'b0;
        busy_c = (state != IDLE);
        run_c  = 1'b0;
        din_c  = '0;
        case (state)
            ISSUE: begin
                run_c = 1'b1;
                din_c = txn.instr;
            end
            IMM:   din_c = txn.imm;
            RESP: begin
                ack_c[grant_q] = 1'b1;
                err_c          = err_q;
            end
            default: ;
        endcase
    end

    assign bus.ack      = ack_c;
    assign bus.err      = err_c;
    assign bus.busy     = busy_c;
    assign bus.cpu_run  = run_c;
    assign bus.cpu_din  = din_c;
    assign bus.grant_id = grant_q;
endmodule
